multi_tick_logic: RTL and testbench
===================================

Name: multi_tick_logic

Overview:
- Parametrised successor of the divided-clock AND stage: an internal programmable tick divider gates sampling of two WIDTH-bit operand buses.
- Each tick applies a runtime-selected bitwise operation (AND/OR/XOR/NAND) and registers the result with a one-cycle valid pulse and a change flag.
- Sits between input-sampling logic and downstream consumers that need rate-reduced, registered combinational results.

Parameters:
WIDTH, 4, bit width of each operand bus and of the result
DIV_W, 8, width of the runtime divide-ratio input and of the internal tick counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
pi_en  in  1  tick counter enable; low freezes the counter and suppresses ticks
pi_div  in  DIV_W  divide ratio N; one tick every N enabled cycles (0 and 1 both mean every enabled cycle)
pi_mode  in  2  operation: 0 AND, 1 OR, 2 XOR, 3 NAND
pi_a  in  WIDTH  operand A
pi_b  in  WIDTH  operand B
po_c  out  WIDTH  registered result
po_valid  out  1  one-cycle pulse, high in the cycle po_c takes a new value
po_changed  out  1  one-cycle pulse with po_valid when the new po_c differs from the previous po_c
po_tick_cnt  out  16  saturating count of results produced since reset

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. Asynchronous reset is not used.
- Reset values: po_c=0, po_valid=0, po_changed=0, po_tick_cnt=0, internal cnt=0.
- Effective ratio R = max(pi_div, 1).
- Tick (internal combinational signal) = pi_en && (cnt >= R-1).
- Counter, when pi_en=1: on a tick, cnt<=0; otherwise cnt<=cnt+1. When pi_en=0, cnt holds.
- Shrinking pi_div below the current cnt therefore produces a tick in the next enabled cycle. No wrap past 2^DIV_W-1 is possible.
- On the edge closing a tick cycle:
  - po_c <= op(pi_a, pi_b, pi_mode). Operands and mode are sampled in the tick cycle only.
  - po_valid <= 1.
  - po_changed <= (new po_c != old po_c).
  - po_tick_cnt <= po_tick_cnt+1, saturating at 16'hFFFF.
- On non-tick cycles: po_valid=0, po_changed=0, po_c holds.
- Latency: operands sampled in tick cycle T; result and pulses are visible in cycle T+1.
- With R=1 and pi_en=1: po_valid is held high continuously and po_c tracks the inputs with one-cycle delay.
- First tick after reset: po_changed compares against the reset value 0. An all-zero result gives po_changed=0.
- rst asserted mid-count: all state returns to reset values at that edge. The first tick occurs R enabled cycles after rst deasserts.
- rst has priority over tick in the same cycle.
- pi_en falling in the same cycle as a would-be tick: no tick. cnt is preserved, and the tick fires on the first cycle pi_en returns high.
- NAND is the bitwise inverse of AND across all WIDTH bits. No arithmetic carries anywhere.

Decomposition:
- Shared package holds:
  - mode encodings MODE_AND=2'd0, MODE_OR=2'd1, MODE_XOR=2'd2, MODE_NAND=2'd3;
  - TICK_CNT_W=16 and TICK_CNT_MAX=16'hFFFF.
- One sub-module is natural: tick_gen (clk, rst, pi_en, pi_div, po_tick), the parametrised generalisation of the fixed divider.
- The operation mux and result/flag registers live in the top module.

Test Plan:
- Reset then idle: rst high 3 cycles, pi_en=0 -> all outputs 0, po_valid never asserts over 20 cycles.
- Divide-by-4 AND, WIDTH=4:
  - pi_div=4, pi_en=1, pi_mode=0, a=4'b1100, b=4'b1010 -> po_valid pulses every 4th cycle with po_c=4'b1000.
  - po_changed=1 on the first pulse only.
  - po_tick_cnt=5 after 5 pulses.
- Mode sweep with pi_div=1:
  - a=4'b1100, b=4'b1010, pi_mode stepping 0,1,2,3 one per cycle -> po_c=1000,1110,0110,0111 on consecutive cycles.
  - po_valid stays high throughout.
  - po_changed=1 each cycle.
- Enable stall: pi_div=5, drop pi_en for 7 cycles after 3 enabled cycles -> the next po_valid arrives exactly 2 enabled cycles after pi_en returns.
- Ratio shrink: pi_div=200 with cnt at 50, change pi_div to 10 -> tick in the next cycle, then every 10 cycles.
- Mid-run reset: assert rst one cycle before an expected tick -> no po_valid, outputs zero. Next po_valid arrives R enabled cycles after release.
- Saturation: force 65536 ticks with pi_div=1 -> po_tick_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/multi_tick_logic_pkg.sv
// Shared encodings for multi_tick_logic: operation select codes and result-counter limits.
package multi_tick_logic_pkg;

   typedef enum logic [1:0] {
      MODE_AND  = 2'd0,
      MODE_OR   = 2'd1,
      MODE_XOR  = 2'd2,
      MODE_NAND = 2'd3
   } mode_e;

   localparam int          TICK_CNT_W   = 16;
   localparam logic [15:0] TICK_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/multi_tick_logic_tick_gen.sv
// Programmable tick divider: combinational tick once every max(pi_div,1) enabled cycles.
// No backpressure; pi_en low freezes the count and masks the tick.
module tick_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pi_en,
   input  logic [DIV_W-1:0] pi_div,
   output logic             po_tick
);

   localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] last_cnt;

   // Ratios 0 and 1 both collapse to a terminal count of 0.
   assign last_cnt = (pi_div == '0) ? '0 : (pi_div - ONE);

   // Using >= lets a shrinking ratio fire straight away instead of wrapping.
   assign po_tick = pi_en && (cnt >= last_cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (pi_en) begin
         if (po_tick) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + ONE;
         end
      end
   end

endmodule

// File: rtl/multi_tick_logic.sv
// Rate-reduced bitwise operator: on each tick registers op(pi_a,pi_b) with valid/changed pulses, latency 1.
// No backpressure; results are presented for one cycle and consumers must take them.
module multi_tick_logic
   import multi_tick_logic_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pi_en,
   input  logic [DIV_W-1:0]      pi_div,
   input  logic [1:0]            pi_mode,
   input  logic [WIDTH-1:0]      pi_a,
   input  logic [WIDTH-1:0]      pi_b,
   output logic [WIDTH-1:0]      po_c,
   output logic                  po_valid,
   output logic                  po_changed,
   output logic [TICK_CNT_W-1:0] po_tick_cnt
);

   logic             tick;
   logic [WIDTH-1:0] op_res;

   tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .pi_en   (pi_en),
      .pi_div  (pi_div),
      .po_tick (tick)
   );

   always_comb begin
      op_res = '0;
      case (pi_mode)
         MODE_AND:  op_res = pi_a & pi_b;
         MODE_OR:   op_res = pi_a | pi_b;
         MODE_XOR:  op_res = pi_a ^ pi_b;
         MODE_NAND: op_res = ~(pi_a & pi_b);
         default:   op_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         po_c        <= '0;
         po_valid    <= 1'b0;
         po_changed  <= 1'b0;
         po_tick_cnt <= '0;
      end else begin
         po_valid   <= tick;
         po_changed <= tick && (op_res != po_c);
         if (tick) begin
            po_c <= op_res;
            if (po_tick_cnt != TICK_CNT_MAX) begin
               po_tick_cnt <= po_tick_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_tick_logic.sv
// Scoreboard bench for multi_tick_logic: directed scenarios plus random traffic against a behavioural model.
module tb_multi_tick_logic;

   logic        clk = 1'b0;
   logic        rst;
   logic        pi_en;
   logic [7:0]  pi_div;
   logic [1:0]  pi_mode;
   logic [3:0]  pi_a;
   logic [3:0]  pi_b;
   logic [3:0]  po_c;
   logic        po_valid;
   logic        po_changed;
   logic [15:0] po_tick_cnt;

   multi_tick_logic #(.WIDTH(4), .DIV_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .pi_en       (pi_en),
      .pi_div      (pi_div),
      .pi_mode     (pi_mode),
      .pi_a        (pi_a),
      .pi_b        (pi_b),
      .po_c        (po_c),
      .po_valid    (po_valid),
      .po_changed  (po_changed),
      .po_tick_cnt (po_tick_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic        zero;
      logic [15:0] n;
   } cyc_t;

   typedef struct packed {
      logic [3:0] c;
      logic       ch;
   } res_t;

   cyc_t exp_cyc[$];
   res_t exp_res[$];

   int n_vec = 0;
   int n_err = 0;

   // Model state: enabled cycles elapsed since the last result, last result, result count.
   int          m_since = 0;
   logic [3:0]  m_c     = '0;
   int          m_cnt   = 0;

   function automatic void chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endfunction

   function automatic logic [3:0] ref_op(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
      case (m)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic step(input logic r, input logic en, input logic [7:0] div,
                       input logic [1:0] mode, input logic [3:0] a, input logic [3:0] b);
      int   ratio;
      bit   t;
      logic [3:0] res;
      @(negedge clk);
      rst = r; pi_en = en; pi_div = div; pi_mode = mode; pi_a = a; pi_b = b;
      ratio = (div == 0) ? 1 : int'(div);
      t = en && (m_since + 1 >= ratio);
      if (r) begin
         m_since = 0; m_c = '0; m_cnt = 0;
         exp_cyc.push_back('{v: 1'b0, zero: 1'b1, n: 16'd0});
      end else begin
         if (t) begin
            res = ref_op(mode, a, b);
            exp_res.push_back('{c: res, ch: (res != m_c)});
            m_c = res;
            if (m_cnt < 65535) m_cnt++;
            m_since = 0;
         end else if (en) begin
            m_since++;
         end
         exp_cyc.push_back('{v: t, zero: 1'b0, n: m_cnt[15:0]});
      end
   endtask

   always @(posedge clk) begin
      cyc_t e;
      res_t r;
      #1;
      if (exp_cyc.size() > 0) begin
         e = exp_cyc.pop_front();
         chk("po_valid", int'(po_valid), int'(e.v));
         chk("po_tick_cnt", int'(po_tick_cnt), int'(e.n));
         if (e.zero) chk("reset_po_c", int'(po_c), 0);
         if (!po_valid) chk("idle_po_changed", int'(po_changed), 0);
         if (po_valid || e.v) begin
            if (exp_res.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               r = exp_res.pop_front();
               if (po_valid) begin
                  chk("po_c", int'(po_c), int'(r.c));
                  chk("po_changed", int'(po_changed), int'(r.ch));
               end
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; pi_en = 1'b0; pi_div = 8'd0; pi_mode = 2'd0; pi_a = '0; pi_b = '0;

      // Reset, then idle with the enable low.
      repeat (3)  step(1, 0, 8'd4, 2'd0, 4'b1100, 4'b1010);
      repeat (20) step(0, 0, 8'd4, 2'd0, 4'b1100, 4'b1010);

      // Divide-by-4 AND: five results of 1000.
      repeat (20) step(0, 1, 8'd4, 2'd0, 4'b1100, 4'b1010);

      // Mode sweep at ratio 1.
      repeat (3) for (int m = 0; m < 4; m++) step(0, 1, 8'd1, m[1:0], 4'b1100, 4'b1010);
      repeat (4) for (int m = 0; m < 4; m++) step(0, 1, 8'd0, m[1:0], 4'b0110, 4'b0011);

      // Enable stall in the middle of a divide-by-5 period.
      step(1, 0, 8'd5, 2'd2, 4'b1111, 4'b0101);
      repeat (3)  step(0, 1, 8'd5, 2'd2, 4'b1111, 4'b0101);
      repeat (7)  step(0, 0, 8'd5, 2'd2, 4'b1111, 4'b0101);
      repeat (12) step(0, 1, 8'd5, 2'd2, 4'b1111, 4'b0101);

      // Ratio shrink from 200 to 10 with 50 cycles already counted.
      step(1, 0, 8'd200, 2'd1, 4'b0001, 4'b1000);
      repeat (50) step(0, 1, 8'd200, 2'd1, 4'b0001, 4'b1000);
      repeat (25) step(0, 1, 8'd10, 2'd1, 4'b0001, 4'b1000);

      // Reset landing in the cycle that would otherwise tick.
      step(1, 0, 8'd6, 2'd3, 4'b0000, 4'b0000);
      repeat (5)  step(0, 1, 8'd6, 2'd3, 4'b0000, 4'b0000);
      step(1, 1, 8'd6, 2'd3, 4'b0000, 4'b0000);
      repeat (14) step(0, 1, 8'd6, 2'd3, 4'b0011, 4'b0101);

      // Random traffic, including ratio changes, enable gaps and rare resets.
      begin
         logic [7:0] div;
         div = 8'd3;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) div = 8'($urandom_range(0, 9));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), div,
                 2'($urandom), 4'($urandom), 4'($urandom));
         end
      end

      // Saturation of the result counter.
      step(1, 0, 8'd1, 2'd0, 4'b0000, 4'b0000);
      for (int i = 0; i < 65540; i++) step(0, 1, 8'd1, 2'($urandom), 4'($urandom), 4'($urandom));
      repeat (4) step(0, 0, 8'd1, 2'd0, 4'b0000, 4'b0000);

      repeat (3) @(posedge clk);
      #2;
      chk("saturated_count", int'(po_tick_cnt), 65535);
      chk("cycle_queue_drained", exp_cyc.size(), 0);
      chk("result_queue_drained", exp_res.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
